// File: rtl/bram128_frame_reader.sv
// bram128_frame_reader
// Read-side controller for a 128 x 9 dual-clock block RAM used as a frame buffer.
// It synchronizes the writer's Gray pointer and issues RAM read addresses.
// A skid FIFO absorbs the RAM read latency, and the block streams the words out
// as valid/ready bytes with an end-of-frame flag.
//
// Ports
//   clk          read-domain clock (same clock as the RAM read port)
//   rst_n        asynchronous active-low reset
//   wr_ptr_gray  writer pointer, Gray-coded, from the write clock domain
//   rd_ptr_gray  captured-word pointer, Gray-coded, back to the write domain
//   addrb        registered RAM read address
//   doutb        RAM read data: [7:0] byte, [8] end-of-frame
//   m_data       output byte
//   m_last       end-of-frame flag for m_data
//   m_valid      output word valid
//   m_ready      downstream accept
//   level        words committed by the writer and not yet captured
//   empty        level == 0 and skid FIFO empty
module bram128_frame_reader #(
   parameter int ADDR_W     = 7,
   parameter int RD_LAT     = 2,
   parameter int SKID_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   wr_ptr_gray,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic [ADDR_W-1:0] addrb,
   input  logic [8:0]        doutb,
   output logic [7:0]        m_data,
   output logic              m_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W:0]   level,
   output logic              empty
);

   localparam int PW      = ADDR_W + 1;
   localparam int SKID_AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int CNT_W   = $clog2(SKID_DEPTH + 1);
   localparam int IF_W    = $clog2(RD_LAT + 1);
   localparam int OCC_W   = $clog2(SKID_DEPTH + RD_LAT + 1);

   logic [PW-1:0]      sync1_reg, sync2_reg;
   logic [PW-1:0]      wr_bin;
   logic [PW-1:0]      issue_ptr_reg, cap_ptr_reg;
   logic [PW-1:0]      avail;
   logic [RD_LAT-1:0]  pipe_reg;
   logic [PW-1:0]      rd_ptr_gray_reg;
   logic [ADDR_W-1:0]  addrb_reg;
   logic [8:0]         skid_mem [SKID_DEPTH];
   logic [SKID_AW-1:0] skid_wr_reg, skid_rd_reg;
   logic [CNT_W-1:0]   skid_count_reg;
   logic [IF_W-1:0]    inflight;
   logic [OCC_W-1:0]   occupancy;
   logic               issue, push, pop;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [SKID_AW-1:0] skid_inc(input logic [SKID_AW-1:0] p);
      return (p == SKID_AW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Two-stage synchronizer for the writer's Gray pointer. Only one bit changes
   // per write-side step, so a sampled value is always either old or new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= wr_ptr_gray;
         sync2_reg <= sync1_reg;
      end
   end

   always_comb begin
      wr_bin         = '0;
      wr_bin[PW-1]   = sync2_reg[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         wr_bin[i] = wr_bin[i+1] ^ sync2_reg[i];
      end
   end

   // Tokens in the read pipe are words already committed to a FIFO slot.
   // Counting them keeps the FIFO from ever being over-subscribed.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + IF_W'(pipe_reg[i]);
      end
   end

   assign avail     = wr_bin - issue_ptr_reg;
   assign occupancy = OCC_W'(skid_count_reg) + OCC_W'(inflight);
   assign issue     = (avail != '0) && (occupancy < OCC_W'(SKID_DEPTH));
   assign push      = pipe_reg[RD_LAT-1];
   assign m_valid   = (skid_count_reg != '0);
   assign pop       = m_valid && m_ready;

   // Token shift pipe: stage 0 loads on the same edge as addrb, so the last
   // stage is set exactly when doutb holds the data for that address.
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_reg[gi] <= 1'b0;
            end else begin
               if (gi == 0) begin
                  pipe_reg[gi] <= issue;
               end else begin
                  pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
               end
            end
         end
      end
   endgenerate

   // Issue and capture pointers. The returned read pointer advances only on
   // capture, so the writer never reuses a slot whose data is still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_ptr_reg   <= '0;
         cap_ptr_reg     <= '0;
         addrb_reg       <= '0;
         rd_ptr_gray_reg <= '0;
      end else begin
         if (issue) begin
            addrb_reg     <= issue_ptr_reg[ADDR_W-1:0];
            issue_ptr_reg <= issue_ptr_reg + 1'b1;
         end
         if (push) begin
            cap_ptr_reg     <= cap_ptr_reg + 1'b1;
            rd_ptr_gray_reg <= bin2gray(cap_ptr_reg + 1'b1);
         end
      end
   end

   // Skid FIFO storage has no reset; validity is carried by the count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         skid_mem[skid_wr_reg] <= doutb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_wr_reg    <= '0;
         skid_rd_reg    <= '0;
         skid_count_reg <= '0;
      end else begin
         if (push) begin
            skid_wr_reg <= skid_inc(skid_wr_reg);
         end
         if (pop) begin
            skid_rd_reg <= skid_inc(skid_rd_reg);
         end
         case ({push, pop})
            2'b10:   skid_count_reg <= skid_count_reg + 1'b1;
            2'b01:   skid_count_reg <= skid_count_reg - 1'b1;
            default: skid_count_reg <= skid_count_reg;
         endcase
      end
   end

   // Head word is masked while empty so stale storage never reaches the outputs.
   assign m_data      = m_valid ? skid_mem[skid_rd_reg][7:0] : 8'h00;
   assign m_last      = m_valid ? skid_mem[skid_rd_reg][8]   : 1'b0;
   assign addrb       = addrb_reg;
   assign rd_ptr_gray = rd_ptr_gray_reg;
   assign level       = wr_bin - cap_ptr_reg;
   assign empty       = (level == '0) && !m_valid;

   a_skid_no_overflow : assert property (
      @(posedge clk) disable iff (!rst_n)
      !(push && !pop && (skid_count_reg == CNT_W'(SKID_DEPTH))));

endmodule
